// File: rtl/reg_alu_pkg.sv
// Shared definitions for the register/ALU command unit.
// Holds the opcode encoding, flag bit positions and FSM state type.
// No logic; imported by reg_alu_exec and reg_alu_unit.
package reg_alu_pkg;

    // Opcodes 9..15 are illegal and execute as NOP with a response.
    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_LOAD = 4'd1,
        OP_MOVE = 4'd2,
        OP_ADD  = 4'd3,
        OP_SUB  = 4'd4,
        OP_INC  = 4'd5,
        OP_CMP  = 4'd6,
        OP_READ = 4'd7,
        OP_MAX  = 4'd8
    } op_e;

    // Bit positions inside the 4-bit flag register {GE, Z, B, C}.
    localparam int FLAG_C  = 0;
    localparam int FLAG_B  = 1;
    localparam int FLAG_Z  = 2;
    localparam int FLAG_GE = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_e;

endpackage

// File: rtl/reg_alu_exec.sv
// Purpose: combinational ALU for reg_alu_unit; maps op/A/B/imm to result, next flags, write enable.
// Latency: zero cycles (pure combinational).
// Backpressure: none; evaluated every cycle, consumed only in the EXEC state.
// Ports: i_op opcode, i_a/i_b latched operands, i_imm LOAD immediate, i_flags current flags,
//        o_result value to write/respond, o_flags_next flags after the op, o_wr_en register write.
// Optional feature: REGALU_MAX_OP_EN enables opcode 8 (MAX); otherwise it is illegal.
module reg_alu_exec
    import reg_alu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [3:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [DATA_W-1:0] i_imm,
    input  logic [3:0]        i_flags,
    output logic [DATA_W-1:0] o_result,
    output logic [3:0]        o_flags_next,
    output logic              o_wr_en
);

    // One extra bit on sum/increment captures the carry-out.
    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_inc;
    logic [DATA_W-1:0] w_diff;
    logic              w_ge;

    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_inc  = {1'b0, i_a} + {{DATA_W{1'b0}}, 1'b1};
    assign w_diff = i_a - i_b;
    assign w_ge   = (i_a >= i_b);

    always_comb begin
        // Non-ALU ops keep the flags; illegal ops return 0 and do not write.
        o_result     = '0;
        o_flags_next = i_flags;
        o_wr_en      = 1'b0;
        case (i_op)
            OP_LOAD: begin
                o_result = i_imm;
                o_wr_en  = 1'b1;
            end
            OP_MOVE: begin
                o_result = i_a;
                o_wr_en  = 1'b1;
            end
            OP_ADD: begin
                o_result             = w_sum[DATA_W-1:0];
                o_wr_en              = 1'b1;
                o_flags_next         = '0;
                o_flags_next[FLAG_C] = w_sum[DATA_W];
                o_flags_next[FLAG_Z] = (w_sum[DATA_W-1:0] == '0);
            end
            OP_SUB: begin
                o_result              = w_diff;
                o_wr_en               = 1'b1;
                o_flags_next          = '0;
                o_flags_next[FLAG_B]  = ~w_ge;
                o_flags_next[FLAG_GE] = w_ge;
                o_flags_next[FLAG_Z]  = (w_diff == '0);
            end
            OP_INC: begin
                o_result             = w_inc[DATA_W-1:0];
                o_wr_en              = 1'b1;
                o_flags_next         = '0;
                o_flags_next[FLAG_C] = w_inc[DATA_W];
                o_flags_next[FLAG_Z] = (w_inc[DATA_W-1:0] == '0);
            end
            OP_CMP: begin
                // Response shows A; Z reports equality rather than a zero result.
                o_result              = i_a;
                o_flags_next          = '0;
                o_flags_next[FLAG_GE] = w_ge;
                o_flags_next[FLAG_Z]  = (i_a == i_b);
            end
            OP_READ: begin
                o_result = i_a;
            end
`ifdef REGALU_MAX_OP_EN
            OP_MAX: begin
                o_result              = w_ge ? i_a : i_b;
                o_wr_en               = 1'b1;
                o_flags_next          = '0;
                o_flags_next[FLAG_GE] = w_ge;
                o_flags_next[FLAG_Z]  = ((w_ge ? i_a : i_b) == '0);
            end
`else
            // MAX not built: behaves exactly like an illegal opcode.
            OP_MAX: begin
                o_result = '0;
            end
`endif
            default: begin
                o_result = '0;
            end
        endcase
    end

endmodule

// File: rtl/reg_alu_unit.sv
// Purpose: command-driven 32x8 register file with ALU; one command per IDLE->FETCH->EXEC pass.
// Latency: accept at edge T, operands at T+1, write/flags at T+2, rsp_valid for the cycle after T+2.
// Backpressure: cmd_ready only in IDLE (1 cmd / 3 cycles); responses cannot be stalled.
// Ports: clk/rst (async active-high), cmd_valid/cmd_ready handshake, cmd_op/dst/src_a/src_b/imm fields,
//        rsp_valid one-cycle pulse with rsp_data result and rsp_flags {GE,Z,B,C}.
// Optional feature: REGALU_MAX_OP_EN (see reg_alu_exec) enables the MAX opcode.
module reg_alu_unit
    import reg_alu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [ADDR_W-1:0] cmd_src_a,
    input  logic [ADDR_W-1:0] cmd_src_b,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [3:0]        rsp_flags
);

    localparam int NREGS = 2 ** ADDR_W;

    state_e            r_state;
    logic [3:0]        r_op;
    logic [ADDR_W-1:0] r_dst;
    logic [ADDR_W-1:0] r_src_a;
    logic [ADDR_W-1:0] r_src_b;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [3:0]        r_flags;
    logic [DATA_W-1:0] r_regs [NREGS];
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;

    logic [DATA_W-1:0] w_result;
    logic [3:0]        w_flags_next;
    logic              w_wr_en;

    reg_alu_exec #(
        .DATA_W (DATA_W)
    ) u_exec (
        .i_op         (r_op),
        .i_a          (r_a),
        .i_b          (r_b),
        .i_imm        (r_imm),
        .i_flags      (r_flags),
        .o_result     (w_result),
        .o_flags_next (w_flags_next),
        .o_wr_en      (w_wr_en)
    );

    // Ready is a straight decode of the state register, so it rises together
    // with rsp_valid and a command can be accepted in the response cycle.
    assign cmd_ready = (r_state == ST_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_flags = r_flags;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_op        <= '0;
            r_dst       <= '0;
            r_src_a     <= '0;
            r_src_b     <= '0;
            r_imm       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_flags     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_op    <= cmd_op;
                        r_dst   <= cmd_dst;
                        r_src_a <= cmd_src_a;
                        r_src_b <= cmd_src_b;
                        r_imm   <= cmd_imm;
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    // Operands are frozen here, so dst aliasing a source uses old values.
                    r_a     <= r_regs[r_src_a];
                    r_b     <= r_regs[r_src_b];
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (w_wr_en) begin
                        r_regs[r_dst] <= w_result;
                    end
                    r_flags     <= w_flags_next;
                    r_rsp_data  <= w_result;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_alu_unit.sv
module tb_reg_alu_unit;
    import reg_alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [4:0] cmd_dst;
    logic [4:0] cmd_src_a;
    logic [4:0] cmd_src_b;
    logic [7:0] cmd_imm;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic [3:0] rsp_flags;

    reg_alu_unit #(.DATA_W(8), .ADDR_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_dst   (cmd_dst),
        .cmd_src_a (cmd_src_a),
        .cmd_src_b (cmd_src_b),
        .cmd_imm   (cmd_imm),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_flags (rsp_flags)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] flags;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    errors = 0;
    int    checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Response monitor: compares every response pulse against the scoreboard head.
    always @(negedge clk) begin
        if (rst === 1'b0 && rsp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
            end else begin
                exp_t  e;
                string t;
                e = sb_q.pop_front();
                t = tag_q.pop_front();
                check({t, "_data"},  {24'd0, rsp_data},  {24'd0, e.data});
                check({t, "_flags"}, {28'd0, rsp_flags}, {28'd0, e.flags});
            end
        end
    end

    // Issues one command, expects the response exactly two edges after the
    // accepting edge, and returns at the negedge of the response cycle.
    task automatic do_cmd(input string tag, input logic [3:0] op, input logic [4:0] dst,
                          input logic [4:0] a, input logic [4:0] b, input logic [7:0] imm,
                          input logic [7:0] exp_data, input logic [3:0] exp_flags);
        int n;
        cmd_op    = op;
        cmd_dst   = dst;
        cmd_src_a = a;
        cmd_src_b = b;
        cmd_imm   = imm;
        cmd_valid = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
        if (cmd_ready !== 1'b1) begin
            cmd_valid = 1'b0;
            return;
        end
        sb_q.push_back('{data: exp_data, flags: exp_flags});
        tag_q.push_back(tag);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 4'($urandom_range(0, 15));
        cmd_dst   = 5'($urandom_range(0, 31));
        check({tag, "_busy"}, {31'd0, cmd_ready}, 32'd0);
        check({tag, "_lat1"}, {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        check({tag, "_lat2"}, {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        check({tag, "_lat3"}, {31'd0, rsp_valid}, 32'd1);
        check({tag, "_rdy_rsp"}, {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_dst   = '0;
        cmd_src_a = '0;
        cmd_src_b = '0;
        cmd_imm   = '0;
        repeat (2) @(negedge clk);
        check("rst_ready",     {31'd0, cmd_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_data",  {24'd0, rsp_data},  32'd0);
        check("rst_rsp_flags", {28'd0, rsp_flags}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Loads and read-back (flags stay 0).
        do_cmd("load_r4", OP_LOAD, 5'd4, 5'd0, 5'd0, 8'd141, 8'd141, 4'b0000);
        do_cmd("load_r6", OP_LOAD, 5'd6, 5'd0, 5'd0, 8'd208, 8'd208, 4'b0000);
        do_cmd("load_r8", OP_LOAD, 5'd8, 5'd0, 5'd0, 8'd32,  8'd32,  4'b0000);
        do_cmd("read_r4", OP_READ, 5'd0, 5'd4, 5'd0, 8'd0,   8'd141, 4'b0000);
        do_cmd("read_r6", OP_READ, 5'd0, 5'd6, 5'd0, 8'd0,   8'd208, 4'b0000);
        do_cmd("read_r8", OP_READ, 5'd0, 5'd8, 5'd0, 8'd0,   8'd32,  4'b0000);
        do_cmd("move_r5", OP_MOVE, 5'd5, 5'd4, 5'd0, 8'd0,   8'd141, 4'b0000);
        do_cmd("read_r5", OP_READ, 5'd0, 5'd5, 5'd0, 8'd0,   8'd141, 4'b0000);

        // Arithmetic; flags are {GE,Z,B,C}.
        do_cmd("add_r10",  OP_ADD, 5'd10, 5'd4, 5'd6, 8'd0, 8'd93,  4'b0001);
        do_cmd("read_r10", OP_READ, 5'd0, 5'd10, 5'd0, 8'd0, 8'd93, 4'b0001);
        do_cmd("sub_r11",  OP_SUB, 5'd11, 5'd6, 5'd8, 8'd0, 8'd176, 4'b1000);
        do_cmd("sub_r12",  OP_SUB, 5'd12, 5'd8, 5'd4, 8'd0, 8'd147, 4'b0010);
        do_cmd("inc_r12",  OP_INC, 5'd12, 5'd12, 5'd0, 8'd0, 8'd148, 4'b0000);
        do_cmd("load_r1",  OP_LOAD, 5'd1, 5'd0, 5'd0, 8'd255, 8'd255, 4'b0000);
        do_cmd("inc_r1",   OP_INC, 5'd1, 5'd1, 5'd0, 8'd0, 8'd0,   4'b0101);
        do_cmd("read_r1",  OP_READ, 5'd0, 5'd1, 5'd0, 8'd0, 8'd0,  4'b0101);

        // Compare: no write, A returned.
        do_cmd("cmp_4_6",  OP_CMP, 5'd4, 5'd4, 5'd6, 8'd0, 8'd141, 4'b0000);
        do_cmd("rd_r4_cmp", OP_READ, 5'd0, 5'd4, 5'd0, 8'd0, 8'd141, 4'b0000);
        do_cmd("rd_r6_cmp", OP_READ, 5'd0, 5'd6, 5'd0, 8'd0, 8'd208, 4'b0000);
        do_cmd("cmp_4_5",  OP_CMP, 5'd0, 5'd4, 5'd5, 8'd0, 8'd141, 4'b1100);
        do_cmd("sub_r13",  OP_SUB, 5'd13, 5'd4, 5'd4, 8'd0, 8'd0,  4'b1100);
        do_cmd("illegal12", 4'd12, 5'd4, 5'd6, 5'd8, 8'd77, 8'd0,  4'b1100);
        do_cmd("rd_r4_ill", OP_READ, 5'd0, 5'd4, 5'd0, 8'd0, 8'd141, 4'b1100);

`ifdef REGALU_MAX_OP_EN
        do_cmd("max_r13",  OP_MAX, 5'd13, 5'd6, 5'd8, 8'd0, 8'd208, 4'b1000);
        do_cmd("read_r13", OP_READ, 5'd0, 5'd13, 5'd0, 8'd0, 8'd208, 4'b1000);
`else
        do_cmd("op8_nop",  OP_MAX, 5'd13, 5'd6, 5'd8, 8'd0, 8'd0,  4'b1100);
        do_cmd("read_r13", OP_READ, 5'd0, 5'd13, 5'd0, 8'd0, 8'd0, 4'b1100);
`endif

        // Reset during FETCH of LOAD R2=7 aborts the command.
        cmd_op    = OP_LOAD;
        cmd_dst   = 5'd2;
        cmd_src_a = 5'd0;
        cmd_src_b = 5'd0;
        cmd_imm   = 8'd7;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("abort_in_fetch", {31'd0, cmd_ready}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ready",     {31'd0, cmd_ready}, 32'd1);
        check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("abort_rsp_flags", {28'd0, rsp_flags}, 32'd0);
        check("abort_rsp_data",  {24'd0, rsp_data},  32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        do_cmd("read_r2_rst", OP_READ, 5'd0, 5'd2, 5'd0, 8'd0, 8'd0, 4'b0000);
        do_cmd("read_r4_rst", OP_READ, 5'd0, 5'd4, 5'd0, 8'd0, 8'd0, 4'b0000);

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
        check("sb_drained", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
